// File: rtl/sseg_scan_decoder_if.sv
// Seven-segment scan bus bundle: multiplexed display inputs plus decoded readback.
// Latency: none, wires only.
// Backpressure: none, the observed display bus cannot be stalled.
//
// Signals:
//    an          4   digit anodes, active-low, an[3] = leftmost digit
//    sseg        7   segments, active-low, {g,f,e,d,c,b,a}
//    digits      16  last complete frame, [15:12] from an[3] ... [3:0] from an[0]
//    frame_valid 1   one-cycle pulse, digits updated in the same cycle
//    pat_err     1   one-cycle pulse, captured segment pattern is not 0-9 and not blank
//    an_err      1   one-cycle pulse, stable capture with more than one anode low
//    frame_tmo   1   one-cycle pulse, partial frame dropped on timeout
interface sseg_scan_decoder_if;
   logic [3:0]  an;
   logic [6:0]  sseg;
   logic [15:0] digits;
   logic        frame_valid;
   logic        pat_err;
   logic        an_err;
   logic        frame_tmo;

   // master drives the display bus and watches the readback
   modport master (
      output an, sseg,
      input  digits, frame_valid, pat_err, an_err, frame_tmo
   );

   // slave is the decoder
   modport slave (
      input  an, sseg,
      output digits, frame_valid, pat_err, an_err, frame_tmo
   );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Observes a multiplexed 4-digit seven-segment bus, debounces each digit dwell,
// decodes to BCD and assembles complete frames.
// Latency: capture STABLE_CYC edges after a pair is first sampled; frame one edge
// after the last digit capture. Backpressure: none (passive monitor).
//
// Ports:
//    clk   in   rising-edge clock
//    R     in   asynchronous active-high reset
//    bus   slave modport of sseg_scan_decoder_if (an/sseg in, digits + pulses out)
module sseg_scan_decoder #(
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                 clk,
   input  logic                 R,
   sseg_scan_decoder_if.slave   bus
);

   localparam int SW = $clog2(STABLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

   state_t        state, state_n;
   logic [3:0]    an_q;
   logic [6:0]    sseg_q;
   logic [SW-1:0] stab_cnt;
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic [15:0]   slots, slots_n;
   logic [3:0]    seen, seen_n;
   logic [15:0]   digits_n;
   logic          fv_n, ft_n;

   logic          chg, cap, one_low, multi_low, dig_cap, err_cap;
   logic [3:0]    an_low;
   logic [3:0]    dec_val;
   logic          dec_bad;

   // A fresh pair at the input compared with the registered one restarts the dwell.
   assign chg = {bus.an, bus.sseg} != {an_q, sseg_q};
   // The edge on which stab_cnt would reach STABLE_CYC is the single capture edge.
   assign cap = !chg && (stab_cnt == SW'(STABLE_CYC - 1));

   assign an_low    = ~an_q;
   assign one_low   = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
   assign multi_low = (an_low != 4'd0) && !one_low;
   assign dig_cap   = cap && one_low;
   assign err_cap   = cap && multi_low;

   always_comb begin
      dec_val = 4'hE;
      dec_bad = 1'b0;
      case (sseg_q)
         7'b1000000: dec_val = 4'd0;
         7'b1111001: dec_val = 4'd1;
         7'b0100100: dec_val = 4'd2;
         7'b0110000: dec_val = 4'd3;
         7'b0011001: dec_val = 4'd4;
         7'b0010010: dec_val = 4'd5;
         7'b0000010: dec_val = 4'd6;
         7'b1111000: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0010000: dec_val = 4'd9;
         7'b1111111: dec_val = 4'hF;
         default: begin
            dec_val = 4'hE;
            dec_bad = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_n  = state;
      seen_n   = seen;
      slots_n  = slots;
      tmo_n    = tmo_cnt;
      digits_n = bus.digits;
      fv_n     = 1'b0;
      ft_n     = 1'b0;

      // Any digit capture writes its slot, whatever the state; bad patterns land as 4'hE.
      if (dig_cap) begin
         for (int i = 0; i < 4; i++) begin
            if (an_low[i]) slots_n[i*4 +: 4] = dec_val;
         end
      end

      case (state)
         IDLE: begin
            if (dig_cap) begin
               seen_n  = an_low;
               tmo_n   = '0;
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            if (dig_cap) begin
               seen_n = seen | an_low;
               tmo_n  = '0;
               if ((seen | an_low) == 4'hF) state_n = EMIT;
            end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
               ft_n    = 1'b1;
               seen_n  = 4'h0;
               tmo_n   = '0;
               state_n = IDLE;
            end else begin
               tmo_n = tmo_cnt + TW'(1);
            end
         end
         EMIT: begin
            // Publish the slots as they stood after the completing capture; a capture
            // landing now already belongs to the next frame.
            digits_n = slots;
            fv_n     = 1'b1;
            tmo_n    = '0;
            if (dig_cap) begin
               seen_n  = an_low;
               state_n = COLLECT;
            end else begin
               seen_n  = 4'h0;
               state_n = IDLE;
            end
         end
         default: begin
            seen_n  = 4'h0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         an_q            <= 4'hF;
         sseg_q          <= 7'h7F;
         stab_cnt        <= '0;
         tmo_cnt         <= '0;
         slots           <= 16'h0000;
         seen            <= 4'h0;
         state           <= IDLE;
         bus.digits      <= 16'h0000;
         bus.frame_valid <= 1'b0;
         bus.pat_err     <= 1'b0;
         bus.an_err      <= 1'b0;
         bus.frame_tmo   <= 1'b0;
      end else begin
         an_q   <= bus.an;
         sseg_q <= bus.sseg;
         if (chg)
            stab_cnt <= '0;
         else if (stab_cnt != SW'(STABLE_CYC))
            stab_cnt <= stab_cnt + SW'(1);
         tmo_cnt         <= tmo_n;
         slots           <= slots_n;
         seen            <= seen_n;
         state           <= state_n;
         bus.digits      <= digits_n;
         bus.frame_valid <= fv_n;
         bus.pat_err     <= dig_cap && dec_bad;
         bus.an_err      <= err_cap;
         bus.frame_tmo   <= ft_n;
      end
   end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: scan stimulus with a frame scoreboard.
// Latency: n/a. Backpressure: n/a.
module tb_sseg_scan_decoder;

   logic clk;
   logic R;

   sseg_scan_decoder_if bus();

   sseg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(4096)) dut (
      .clk (clk),
      .R   (R),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int fv_cnt = 0;
   int pe_cnt = 0;
   int ae_cnt = 0;
   int ft_cnt = 0;
   int ft_cyc = 0;

   logic [15:0] exp_q[$];

   localparam logic [6:0] BLANK = 7'b1111111;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0010000;
         default: return BLANK;
      endcase
   endfunction

   // Scoreboard side: every frame_valid pops one expected frame.
   always @(negedge clk) begin
      if (bus.frame_valid) begin
         fv_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected digits=%h required=no frame", bus.digits);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (bus.digits !== e) begin
               errors++;
               $display("FAIL frame_digits got=%h required=%h", bus.digits, e);
            end
         end
      end
      if (bus.pat_err)   pe_cnt++;
      if (bus.an_err)    ae_cnt++;
      if (bus.frame_tmo) begin
         ft_cnt++;
         ft_cyc = cyc;
      end
   end

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      bus.an   = a;
      bus.sseg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input int dwell, input bit push,
                       input logic [15:0] e);
      if (push) exp_q.push_back(e);
      hold(4'b1110, s0, dwell);
      hold(4'b1101, s1, dwell);
      hold(4'b1011, s2, dwell);
      hold(4'b0111, s3, dwell);
   endtask

   task automatic do_reset();
      R = 1'b1;
      hold(4'hF, BLANK, 2);
      R = 1'b0;
      hold(4'hF, BLANK, 5);
   endtask

   task automatic test_reset();
      checks++;
      if (bus.digits !== 16'h0000) begin
         errors++; $display("FAIL reset_digits got=%h required=0000", bus.digits);
      end
      checks++;
      if (bus.frame_valid !== 1'b0) begin
         errors++; $display("FAIL reset_frame_valid got=%b required=0", bus.frame_valid);
      end
      checks++;
      if (bus.pat_err !== 1'b0) begin
         errors++; $display("FAIL reset_pat_err got=%b required=0", bus.pat_err);
      end
      checks++;
      if (bus.an_err !== 1'b0) begin
         errors++; $display("FAIL reset_an_err got=%b required=0", bus.an_err);
      end
      checks++;
      if (bus.frame_tmo !== 1'b0) begin
         errors++; $display("FAIL reset_frame_tmo got=%b required=0", bus.frame_tmo);
      end
   endtask

   task automatic test_scan();
      int fv0, pe0, ae0;
      fv0 = fv_cnt; pe0 = pe_cnt; ae0 = ae_cnt;
      scan(seg(1), seg(2), seg(5), seg(9), 8, 1'b1, 16'h9521);
      scan(seg(1), seg(2), seg(5), seg(9), 8, 1'b1, 16'h9521);
      hold(4'hF, BLANK, 10);
      checks++;
      if (fv_cnt - fv0 !== 2) begin
         errors++; $display("FAIL scan_frame_count got=%0d required=2", fv_cnt - fv0);
      end
      checks++;
      if (bus.digits !== 16'h9521) begin
         errors++; $display("FAIL scan_digits got=%h required=9521", bus.digits);
      end
      checks++;
      if ((pe_cnt - pe0) + (ae_cnt - ae0) !== 0) begin
         errors++; $display("FAIL scan_err_pulses got=%0d required=0",
                            (pe_cnt - pe0) + (ae_cnt - ae0));
      end
      // Minimum capturing dwell is STABLE_CYC+1 samples; include a blank digit.
      fv0 = fv_cnt;
      scan(seg(3), seg(4), seg(6), seg(7), 5, 1'b1, 16'h7643);
      scan(seg(0), seg(8), BLANK, seg(7), 5, 1'b1, 16'h7F80);
      hold(4'hF, BLANK, 10);
      checks++;
      if (fv_cnt - fv0 !== 2) begin
         errors++; $display("FAIL min_dwell_frame_count got=%0d required=2", fv_cnt - fv0);
      end
      checks++;
      if (bus.digits !== 16'h7F80) begin
         errors++; $display("FAIL blank_digits got=%h required=7F80", bus.digits);
      end
   endtask

   task automatic test_short_dwell();
      int fv0;
      do_reset();
      fv0 = fv_cnt;
      scan(seg(1), seg(2), seg(5), seg(9), 3, 1'b0, 16'h0);
      scan(seg(1), seg(2), seg(5), seg(9), 4, 1'b0, 16'h0);
      scan(seg(1), seg(2), seg(5), seg(9), 3, 1'b0, 16'h0);
      hold(4'hF, BLANK, 10);
      checks++;
      if (fv_cnt - fv0 !== 0) begin
         errors++; $display("FAIL short_dwell_frames got=%0d required=0", fv_cnt - fv0);
      end
      checks++;
      if (bus.digits !== 16'h0000) begin
         errors++; $display("FAIL short_dwell_digits got=%h required=0000", bus.digits);
      end
   endtask

   task automatic test_an_err();
      int fv0, ae0;
      fv0 = fv_cnt; ae0 = ae_cnt;
      hold(4'b1100, seg(0), 6);
      hold(4'hF, BLANK, 10);
      checks++;
      if (ae_cnt - ae0 !== 1) begin
         errors++; $display("FAIL an_err_count got=%0d required=1", ae_cnt - ae0);
      end
      // If the multi-anode capture had marked digits 0/1 seen, these two would finish a frame.
      hold(4'b1011, seg(4), 8);
      hold(4'b0111, seg(2), 8);
      hold(4'hF, BLANK, 20);
      checks++;
      if (fv_cnt - fv0 !== 0) begin
         errors++; $display("FAIL an_err_seen_frames got=%0d required=0", fv_cnt - fv0);
      end
      exp_q.push_back(16'h2406);
      hold(4'b1110, seg(6), 8);
      hold(4'b1101, seg(0), 8);
      hold(4'hF, BLANK, 5);
      checks++;
      if (fv_cnt - fv0 !== 1) begin
         errors++; $display("FAIL an_err_resume_frames got=%0d required=1", fv_cnt - fv0);
      end
   endtask

   task automatic test_pat_err();
      int fv0, pe0;
      fv0 = fv_cnt; pe0 = pe_cnt;
      scan(7'b1010101, seg(5), seg(7), seg(3), 8, 1'b1, 16'h375E);
      hold(4'hF, BLANK, 5);
      checks++;
      if (pe_cnt - pe0 !== 1) begin
         errors++; $display("FAIL pat_err_count got=%0d required=1", pe_cnt - pe0);
      end
      checks++;
      if (fv_cnt - fv0 !== 1) begin
         errors++; $display("FAIL pat_err_frames got=%0d required=1", fv_cnt - fv0);
      end
      checks++;
      if (bus.digits !== 16'h375E) begin
         errors++; $display("FAIL pat_err_digits got=%h required=375E", bus.digits);
      end
   endtask

   task automatic test_timeout();
      int fv0, ft0, start, waited, rel;
      fv0 = fv_cnt; ft0 = ft_cnt;
      hold(4'b1110, seg(4), 8);
      hold(4'b1101, seg(3), 8);
      start = cyc;
      hold(4'b1011, seg(2), 8);
      bus.an   = 4'hF;
      bus.sseg = BLANK;
      waited = 0;
      while (ft_cnt == ft0 && waited < 4300) begin
         @(posedge clk);
         waited++;
      end
      @(posedge clk); #1;
      checks++;
      if (ft_cnt - ft0 !== 1) begin
         errors++; $display("FAIL timeout_pulses got=%0d required=1", ft_cnt - ft0);
      end
      // Last capture lands 5 edges into the dwell; drop follows ~TIMEOUT_CYC edges later.
      rel = ft_cyc - start;
      checks++;
      if (rel < 4100 || rel > 4101) begin
         errors++; $display("FAIL timeout_timing got=%0d required=4100..4101", rel);
      end
      checks++;
      if (fv_cnt - fv0 !== 0 || bus.digits !== 16'h375E) begin
         errors++; $display("FAIL timeout_partial got frames=%0d digits=%h required 0/375E",
                            fv_cnt - fv0, bus.digits);
      end
      scan(seg(4), seg(3), seg(2), seg(1), 8, 1'b1, 16'h1234);
      hold(4'hF, BLANK, 5);
      checks++;
      if (fv_cnt - fv0 !== 1 || bus.digits !== 16'h1234) begin
         errors++; $display("FAIL timeout_recover got frames=%0d digits=%h required 1/1234",
                            fv_cnt - fv0, bus.digits);
      end
   endtask

   task automatic test_reset_mid();
      int fv0, ft0;
      fv0 = fv_cnt; ft0 = ft_cnt;
      scan(seg(8), seg(1), seg(3), seg(0), 8, 1'b1, 16'h0318);
      hold(4'b1110, seg(5), 8);
      hold(4'b1101, seg(6), 3);
      #3;
      R = 1'b1;
      #1;
      checks++;
      if (bus.digits !== 16'h0000) begin
         errors++; $display("FAIL async_reset_digits got=%h required=0000", bus.digits);
      end
      checks++;
      if (bus.frame_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset_fv got=%b required=0", bus.frame_valid);
      end
      hold(4'hF, BLANK, 3);
      R = 1'b0;
      hold(4'hF, BLANK, 10);
      checks++;
      if (fv_cnt - fv0 !== 1 || ft_cnt - ft0 !== 0) begin
         errors++; $display("FAIL reset_mid_pulses got frames=%0d tmo=%0d required 1/0",
                            fv_cnt - fv0, ft_cnt - ft0);
      end
      scan(seg(2), seg(7), seg(9), seg(4), 8, 1'b1, 16'h4972);
      hold(4'hF, BLANK, 5);
      checks++;
      if (fv_cnt - fv0 !== 2 || bus.digits !== 16'h4972) begin
         errors++; $display("FAIL reset_mid_next got frames=%0d digits=%h required 2/4972",
                            fv_cnt - fv0, bus.digits);
      end
   endtask

   initial begin
      R        = 1'b1;
      bus.an   = 4'hF;
      bus.sseg = BLANK;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      R = 1'b0;
      hold(4'hF, BLANK, 5);
      test_scan();
      test_short_dwell();
      test_an_err();
      test_pat_err();
      test_timeout();
      test_reset_mid();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
